// File: rtl/conv2d_backprop.sv
// conv2d_backprop: ReLU-masked conv2d kernel update, one kernel tap per cycle.
// Define CONV_BP_INPUT_GRAD_EN to also compute dL_dinput, one pixel per cycle.
module conv2d_backprop #(
  parameter int IN_SIZE = 4,
  parameter int KERNEL_SIZE = 3,
  localparam int OUT_SIZE = IN_SIZE - KERNEL_SIZE + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic signed [15:0] input_feature [IN_SIZE][IN_SIZE],
  input  logic signed [15:0] conv_out [OUT_SIZE][OUT_SIZE],
  input  logic signed [15:0] dL_dact [OUT_SIZE][OUT_SIZE],
  input  logic signed [15:0] learning_rate,
  input  logic signed [15:0] weights_in [KERNEL_SIZE][KERNEL_SIZE],
  output logic signed [15:0] weights_out [KERNEL_SIZE][KERNEL_SIZE],
  output logic signed [15:0] dL_dinput [IN_SIZE][IN_SIZE],
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(IN_SIZE) + 1;
  typedef enum logic [1:0] {
    IDLE, MASK, WGRAD
`ifdef CONV_BP_INPUT_GRAD_EN
    , IGRAD
`endif
  } state_t;
  state_t state_q, state_d;
  logic done_q, done_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic signed [15:0] in_q [IN_SIZE][IN_SIZE], in_d [IN_SIZE][IN_SIZE];
  logic neg_q [OUT_SIZE][OUT_SIZE], neg_d [OUT_SIZE][OUT_SIZE];
  logic signed [15:0] g_q [OUT_SIZE][OUT_SIZE], g_d [OUT_SIZE][OUT_SIZE];
  logic signed [15:0] lr_q, lr_d;
  logic signed [15:0] w_q [KERNEL_SIZE][KERNEL_SIZE], w_d [KERNEL_SIZE][KERNEL_SIZE];
  logic signed [15:0] wo_q [KERNEL_SIZE][KERNEL_SIZE], wo_d [KERNEL_SIZE][KERNEL_SIZE];
  logic signed [39:0] acc;
  logic signed [15:0] grad;
  logic signed [31:0] upd;
  int ri, ci;
  logic unused;
  // r/c index the current kernel tap (m,n) in WGRAD and the pixel (i,j) in IGRAD
  always_comb begin
    ri = int'(r_q);
    ci = int'(c_q);
    acc = '0;
    for (int x = 0; x < OUT_SIZE; x++)
      for (int y = 0; y < OUT_SIZE; y++)
        acc = acc + 40'(32'(in_q[x+ri][y+ci]) * 32'(g_q[x][y]));
    grad = acc[23:8];
    upd = 32'(lr_q) * 32'(grad);
  end
`ifdef CONV_BP_INPUT_GRAD_EN
  logic signed [15:0] di_q [IN_SIZE][IN_SIZE], di_d [IN_SIZE][IN_SIZE];
  logic signed [39:0] acc_i;
  // transposed convolution of the masked gradient with the captured kernel
  always_comb begin
    acc_i = '0;
    for (int x = 0; x < OUT_SIZE; x++)
      for (int y = 0; y < OUT_SIZE; y++)
        if (ri >= x && ri - x < KERNEL_SIZE && ci >= y && ci - y < KERNEL_SIZE)
          acc_i = acc_i + 40'(32'(w_q[ri-x][ci-y]) * 32'(g_q[x][y]));
  end
  assign dL_dinput = di_q;
  assign unused = ^{acc[39:24], acc[7:0], upd[31:24], upd[7:0], acc_i[39:24], acc_i[7:0]};
`else
  assign dL_dinput = '{default: '0};
  assign unused = ^{acc[39:24], acc[7:0], upd[31:24], upd[7:0]};
`endif
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    r_d = r_q;
    c_d = c_q;
    in_d = in_q;
    neg_d = neg_q;
    g_d = g_q;
    lr_d = lr_q;
    w_d = w_q;
    wo_d = wo_q;
`ifdef CONV_BP_INPUT_GRAD_EN
    di_d = di_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        state_d = MASK;
        r_d = '0;
        c_d = '0;
        in_d = input_feature;
        g_d = dL_dact;
        lr_d = learning_rate;
        w_d = weights_in;
        for (int x = 0; x < OUT_SIZE; x++)
          for (int y = 0; y < OUT_SIZE; y++)
            neg_d[x][y] = conv_out[x][y][15];
      end
      MASK: begin
        state_d = WGRAD;
        for (int x = 0; x < OUT_SIZE; x++)
          for (int y = 0; y < OUT_SIZE; y++)
            g_d[x][y] = neg_q[x][y] ? '0 : g_q[x][y];
      end
      WGRAD: begin
        wo_d[ri][ci] = w_q[ri][ci] - upd[23:8];
        c_d = (c_q == CW'(KERNEL_SIZE-1)) ? '0 : c_q + CW'(1);
        r_d = (c_q == CW'(KERNEL_SIZE-1)) ? r_q + CW'(1) : r_q;
        if (r_q == CW'(KERNEL_SIZE-1) && c_q == CW'(KERNEL_SIZE-1)) begin
`ifdef CONV_BP_INPUT_GRAD_EN
          state_d = IGRAD;
          r_d = '0;
          c_d = '0;
`else
          state_d = IDLE;
          done_d = 1'b1;
`endif
        end
      end
`ifdef CONV_BP_INPUT_GRAD_EN
      IGRAD: begin
        di_d[ri][ci] = acc_i[23:8];
        c_d = (c_q == CW'(IN_SIZE-1)) ? '0 : c_q + CW'(1);
        r_d = (c_q == CW'(IN_SIZE-1)) ? r_q + CW'(1) : r_q;
        if (r_q == CW'(IN_SIZE-1) && c_q == CW'(IN_SIZE-1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      r_q <= '0;
      c_q <= '0;
      in_q <= '{default: '0};
      neg_q <= '{default: 1'b0};
      g_q <= '{default: '0};
      lr_q <= '0;
      w_q <= '{default: '0};
      wo_q <= '{default: '0};
`ifdef CONV_BP_INPUT_GRAD_EN
      di_q <= '{default: '0};
`endif
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      r_q <= r_d;
      c_q <= c_d;
      in_q <= in_d;
      neg_q <= neg_d;
      g_q <= g_d;
      lr_q <= lr_d;
      w_q <= w_d;
      wo_q <= wo_d;
`ifdef CONV_BP_INPUT_GRAD_EN
      di_q <= di_d;
`endif
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign weights_out = wo_q;
endmodule

// File: tb/tb_conv2d_backprop.sv
// tb_conv2d_backprop: vector table, directed corners and random operations against a behavioural model.
module tb_conv2d_backprop;
  localparam int IN = 4, K = 3, OS = IN - K + 1;
`ifdef CONV_BP_INPUT_GRAD_EN
  localparam int LAT = 1 + K*K + IN*IN;
`else
  localparam int LAT = 1 + K*K;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic signed [15:0] inf [IN][IN];
  logic signed [15:0] co [OS][OS];
  logic signed [15:0] da [OS][OS];
  logic signed [15:0] lr;
  logic signed [15:0] wi [K][K];
  logic signed [15:0] wo [K][K];
  logic signed [15:0] di [IN][IN];
  logic signed [15:0] exp_w [K][K];
  logic signed [15:0] exp_di [IN][IN];
  logic busy, done;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [15:0] in_v, co_v, da_v, lr_v, w_v, exp_v; } vec_t;
  vec_t vecs [5];

  conv2d_backprop #(.IN_SIZE(IN), .KERNEL_SIZE(K)) dut (
    .clk(clk), .rst(rst), .start(start), .input_feature(inf), .conv_out(co),
    .dL_dact(da), .learning_rate(lr), .weights_in(wi), .weights_out(wo),
    .dL_dinput(di), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic fill(input logic [15:0] iv, cv, dv, lv, wv);
    foreach (inf[i, j]) inf[i][j] = iv;
    foreach (co[i, j]) co[i][j] = cv;
    foreach (da[i, j]) da[i][j] = dv;
    lr = lv;
    foreach (wi[i, j]) wi[i][j] = wv;
  endtask

  task automatic rand_inputs();
    foreach (inf[i, j]) inf[i][j] = 16'($urandom);
    foreach (co[i, j]) co[i][j] = 16'($urandom);
    foreach (da[i, j]) da[i][j] = 16'($urandom);
    lr = 16'($urandom);
    foreach (wi[i, j]) wi[i][j] = 16'($urandom);
  endtask

  // Expected results straight from the gradient equations, in wide integer arithmetic
  function automatic void model();
    logic signed [15:0] g [OS][OS];
    logic signed [15:0] gr;
    longint s, u;
    foreach (g[x, y]) g[x][y] = (co[x][y] < 0) ? 16'sd0 : da[x][y];
    foreach (exp_w[m, n]) begin
      s = 0;
      foreach (g[x, y]) s += longint'(inf[x+m][y+n]) * longint'(g[x][y]);
      gr = 16'(s >>> 8);
      u = longint'(lr) * longint'(gr);
      exp_w[m][n] = wi[m][n] - 16'(u >>> 8);
    end
    foreach (exp_di[i, j]) begin
      s = 0;
`ifdef CONV_BP_INPUT_GRAD_EN
      foreach (g[x, y])
        if (i - x >= 0 && i - x < K && j - y >= 0 && j - y < K)
          s += longint'(wi[i-x][j-y]) * longint'(g[x][y]);
`endif
      exp_di[i][j] = 16'(s >>> 8);
    end
  endfunction

  task automatic check_outputs(input string tag);
    foreach (wo[m, n]) chk($sformatf("%s w[%0d][%0d]", tag, m, n), wo[m][n], exp_w[m][n]);
    foreach (di[i, j]) chk($sformatf("%s dinput[%0d][%0d]", tag, i, j), di[i][j], exp_di[i][j]);
  endtask

  task automatic op(input string tag, input bit scramble);
    int k;
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " busy"}, 16'(busy), 16'd1);
    if (scramble) rand_inputs();
    k = 0;
    while (!done && k < LAT + 4) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, " latency"}, 16'(k), 16'(LAT));
    chk({tag, " busy_at_done"}, 16'(busy), 16'd0);
    check_outputs(tag);
    @(posedge clk);
    #1;
    chk({tag, " done_width"}, 16'(done), 16'd0);
  endtask

  initial begin
    int nd, d1, d2;
    vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'hFC00};
    vecs[1] = '{16'h0234, 16'hFF00, 16'h0777, 16'h0100, 16'h1234, 16'h1234};
    vecs[2] = '{16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0100, 16'h0000};
    vecs[3] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0100, 16'h7F00, 16'h8300};
    vecs[4] = '{16'h5555, 16'h0000, 16'h0000, 16'h7FFF, 16'hABCD, 16'hABCD};
    fill(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    foreach (wo[m, n]) chk($sformatf("reset w[%0d][%0d]", m, n), wo[m][n], 16'h0);
    foreach (di[i, j]) chk($sformatf("reset dinput[%0d][%0d]", i, j), di[i][j], 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].in_v, vecs[v].co_v, vecs[v].da_v, vecs[v].lr_v, vecs[v].w_v);
      op($sformatf("vec%0d", v), 1'b0);
      foreach (wo[m, n]) chk($sformatf("vec%0d table w[%0d][%0d]", v, m, n), wo[m][n], vecs[v].exp_v);
    end
    fill(16'h0, 16'h0100, 16'h0, 16'h0080, 16'h0);
    foreach (inf[i, j]) inf[i][j] = 16'((4*i + j) << 8);
    da[0][0] = 16'h0100;
    op("ramp", 1'b0);
    foreach (wo[m, n]) chk($sformatf("ramp table w[%0d][%0d]", m, n), wo[m][n], 16'(-(4*m + n) * 128));
    chk("ramp w22", wo[2][2], 16'hFB00);
`ifdef CONV_BP_INPUT_GRAD_EN
    fill(16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    op("igrad", 1'b0);
    chk("igrad di00", di[0][0], 16'h0100);
    chk("igrad di01", di[0][1], 16'h0200);
    chk("igrad di11", di[1][1], 16'h0400);
    chk("igrad di33", di[3][3], 16'h0100);
`endif
    for (int r = 0; r < 8; r++) begin
      rand_inputs();
      op($sformatf("rand%0d", r), 1'b1);
    end
    fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    nd = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 2*LAT + 1; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (nd == 1) d1 = k; else d2 = k;
      end
    end
    start = 1'b0;
    chk("b2b done_count", 16'(nd), 16'd2);
    chk("b2b first_done", 16'(d1), 16'(LAT));
    chk("b2b second_done", 16'(d2), 16'(2*LAT + 1));
    check_outputs("b2b");
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("b2b no_extra_done", 16'(nd), 16'd2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    foreach (wo[m, n]) chk($sformatf("abort w[%0d][%0d]", m, n), wo[m][n], 16'h0);
    foreach (di[i, j]) chk($sformatf("abort dinput[%0d][%0d]", i, j), di[i][j], 16'h0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("abort no_done", 16'(nd), 16'd0);
    op("post_reset", 1'b0);
    foreach (wo[m, n]) chk($sformatf("post_reset table w[%0d][%0d]", m, n), wo[m][n], 16'hFC00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1);
  end
endmodule
